// File: rtl/render_pkg.sv
// Shared types and constants for the layer compositor slice.
package render_pkg;

    typedef enum logic [1:0] {
        MENU     = 2'd0,
        PLAYING  = 2'd1,
        CONTINUE = 2'd2,
        FINAL    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

    // Cycles from de_i/pixel inputs to rgb_o/de_o.
    localparam int unsigned LATENCY = 2;

    // Width of one colour channel in a packed {blue, green, red} pixel.
    function automatic int unsigned chan_bits(input int unsigned color_bits);
        return color_bits / 3;
    endfunction

endpackage

// File: rtl/layer_compositor_fade_scaler.sv
// One colour channel scaled by the fade level, registered.
module fade_scaler #(
    parameter int unsigned CW        = 8,
    parameter int unsigned FADE_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CW-1:0]        chan_i,
    input  logic [FADE_BITS:0]   lvl_i,
    output logic [CW-1:0]        chan_o
);

    localparam int unsigned PW = CW + FADE_BITS + 1;

    logic [PW-1:0] prod;
    logic [CW-1:0] chan_d;
    logic [CW-1:0] chan_q;
    logic          unused_bits;

    // Multiply-shift: full level (2**FADE_BITS) returns the channel unchanged.
    always_comb begin
        prod        = PW'(chan_i) * PW'(lvl_i);
        chan_d      = prod[FADE_BITS +: CW];
        unused_bits = ^{prod[PW-1], prod[FADE_BITS-1:0]};
    end

    // Output register forming the second pipeline stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chan_q <= '0;
        end else begin
            chan_q <= chan_d;
        end
    end

    assign chan_o = chan_q;

endmodule

// File: rtl/layer_compositor.sv
// Priority/colour-key layer compositor with mode-change fade FSM and
// a two-stage pixel pipeline (select, then scale).
module layer_compositor
    import render_pkg::*;
#(
    parameter int unsigned              COLOR_BITS = 24,
    parameter int unsigned              NUM_LAYERS = 4,
    parameter logic [COLOR_BITS-1:0]    KEY_COLOR  = 24'h000000,
    parameter logic [COLOR_BITS-1:0]    BG_COLOR   = 24'hE0E0E0,
    parameter int unsigned              FADE_BITS  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             de_i,
    input  logic                             hsync_i,
    input  logic                             vsync_i,
    input  logic                             frame_start_i,
    input  logic [1:0]                       mode_i,
    input  logic [COLOR_BITS-1:0]            menu_rgb_i,
    input  logic [NUM_LAYERS*COLOR_BITS-1:0] layer_rgb_i,
    input  logic [NUM_LAYERS-1:0]            layer_en_i,
    output logic [COLOR_BITS-1:0]            rgb_o,
    output logic                             de_o,
    output logic                             hsync_o,
    output logic                             vsync_o,
    output logic                             busy_o
);

    localparam int unsigned        CW       = chan_bits(COLOR_BITS);
    localparam logic [FADE_BITS:0] LVL_FULL = {1'b1, {FADE_BITS{1'b0}}};
    localparam logic [FADE_BITS:0] LVL_ONE  = {{FADE_BITS{1'b0}}, 1'b1};

    fade_state_e            state_q;
    mode_e                  active_mode_q;
    mode_e                  target_q;
    mode_e                  mode_req;
    logic [FADE_BITS:0]     lvl_q;
    logic                   busy_q;

    logic [COLOR_BITS-1:0]  src_d;
    logic [COLOR_BITS-1:0]  src_q;
    logic [FADE_BITS:0]     lvl_s1_q;
    logic [1:0]             de_q;
    logic [1:0]             hs_q;
    logic [1:0]             vs_q;

    assign mode_req = mode_e'(mode_i);

    // Fade FSM: mode requests reach active_mode only at the dark point of a fade.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SHOW;
            active_mode_q <= MENU;
            target_q      <= MENU;
            lvl_q         <= LVL_FULL;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                SHOW: begin
                    if (mode_req != active_mode_q) begin
                        target_q <= mode_req;
                        state_q  <= FADE_OUT;
                        busy_q   <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    target_q <= mode_req;
                    if (frame_start_i) begin
                        if (lvl_q <= LVL_ONE) begin
                            lvl_q         <= '0;
                            active_mode_q <= target_q;
                            state_q       <= FADE_IN;
                        end else begin
                            lvl_q <= lvl_q - LVL_ONE;
                        end
                    end
                end
                FADE_IN: begin
                    if (mode_req != active_mode_q) begin
                        target_q <= mode_req;
                        state_q  <= FADE_OUT;
                    end else if (frame_start_i) begin
                        lvl_q <= lvl_q + LVL_ONE;
                        if (lvl_q + LVL_ONE == LVL_FULL) begin
                            state_q <= SHOW;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= SHOW;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Source select; the scan runs high index to low so layer 0 wins last.
    always_comb begin
        src_d = '0;
        if (de_i) begin
            case (active_mode_q)
                MENU: src_d = menu_rgb_i;
                PLAYING: begin
                    src_d = BG_COLOR;
                    for (int unsigned k = NUM_LAYERS; k > 0; k--) begin
                        if (layer_en_i[k-1] &&
                            layer_rgb_i[(k-1)*COLOR_BITS +: COLOR_BITS] != KEY_COLOR) begin
                            src_d = layer_rgb_i[(k-1)*COLOR_BITS +: COLOR_BITS];
                        end
                    end
                end
                default: src_d = BG_COLOR;
            endcase
        end
    end

    // Stage 1: selected source and the level in force for it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q    <= '0;
            lvl_s1_q <= '0;
        end else begin
            src_q    <= src_d;
            lvl_s1_q <= lvl_q;
        end
    end

    // Two-stage delay for sync and data-enable, matching the pixel path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_q <= '0;
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            de_q <= {de_q[0], de_i};
            hs_q <= {hs_q[0], hsync_i};
            vs_q <= {vs_q[0], vsync_i};
        end
    end

    // Stage 2: per-channel scaling.
    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        fade_scaler #(
            .CW        (CW),
            .FADE_BITS (FADE_BITS)
        ) u_scaler (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .chan_i (src_q[ch*CW +: CW]),
            .lvl_i  (lvl_s1_q),
            .chan_o (rgb_o[ch*CW +: CW])
        );
    end

    assign de_o    = de_q[1];
    assign hsync_o = hs_q[1];
    assign vsync_o = vs_q[1];
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: randomized pixels, directed mode sequences.
module tb_layer_compositor;

    localparam int          CB    = 24;
    localparam int          NL    = 4;
    localparam int          FB    = 4;
    localparam int          FULL  = 16;
    localparam int          FLEN  = 6;
    localparam logic [23:0] KEY   = 24'h000000;
    localparam logic [23:0] BG    = 24'hE0E0E0;

    logic             clk;
    logic             rst_i;
    logic             de_i, hsync_i, vsync_i, frame_start_i;
    logic [1:0]       mode_i;
    logic [CB-1:0]    menu_rgb_i;
    logic [NL*CB-1:0] layer_rgb_i;
    logic [NL-1:0]    layer_en_i;
    logic [CB-1:0]    rgb_o;
    logic             de_o, hsync_o, vsync_o, busy_o;

    layer_compositor #(
        .COLOR_BITS (CB),
        .NUM_LAYERS (NL),
        .KEY_COLOR  (KEY),
        .BG_COLOR   (BG),
        .FADE_BITS  (FB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .de_i          (de_i),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .frame_start_i (frame_start_i),
        .mode_i        (mode_i),
        .menu_rgb_i    (menu_rgb_i),
        .layer_rgb_i   (layer_rgb_i),
        .layer_en_i    (layer_en_i),
        .rgb_o         (rgb_o),
        .de_o          (de_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   started = 0;

    // Reference: 0 = steady, 1 = darkening, 2 = brightening
    int   m_phase  = 0;
    int   m_mode   = 0;
    int   m_target = 0;
    int   m_lvl    = FULL;
    bit   m_busy   = 0;

    function automatic logic [23:0] ref_src(int mode, bit de, logic [23:0] menu,
                                            logic [95:0] lay, logic [3:0] en);
        if (!de) return 24'h0;
        if (mode == 0) return menu;
        if (mode == 1) begin
            for (int k = 0; k < NL; k++)
                if (en[k] && lay[k*24 +: 24] != KEY) return lay[k*24 +: 24];
            return BG;
        end
        return BG;
    endfunction

    function automatic logic [23:0] ref_scale(logic [23:0] px, int lvl);
        logic [23:0] r;
        r = 24'h0;
        for (int ch = 0; ch < 3; ch++) begin
            int c;
            c = int'(px[ch*8 +: 8]);
            r[ch*8 +: 8] = 8'((c * lvl) / FULL);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference update at a clock edge, using the inputs just sampled.
    task automatic model_step();
        exp_t e;
        if (rst_i) begin
            q.delete();
            e.rgb = '0; e.de = 0; e.hs = 0; e.vs = 0;
            q.push_back(e);
            q.push_back(e);
            m_phase = 0; m_mode = 0; m_target = 0; m_lvl = FULL; m_busy = 0;
            return;
        end
        e.rgb = ref_scale(ref_src(m_mode, de_i, menu_rgb_i, layer_rgb_i, layer_en_i), m_lvl);
        e.de  = de_i;
        e.hs  = hsync_i;
        e.vs  = vsync_i;
        q.push_back(e);
        if (m_phase == 0) begin
            if (int'(mode_i) != m_mode) begin
                m_target = int'(mode_i);
                m_phase  = 1;
            end
        end else if (m_phase == 1) begin
            if (frame_start_i) begin
                if (m_lvl <= 1) begin
                    m_lvl   = 0;
                    m_mode  = m_target;
                    m_phase = 2;
                end else begin
                    m_lvl = m_lvl - 1;
                end
            end
            m_target = int'(mode_i);
        end else begin
            if (int'(mode_i) != m_mode) begin
                m_target = int'(mode_i);
                m_phase  = 1;
            end else if (frame_start_i) begin
                m_lvl = m_lvl + 1;
                if (m_lvl == FULL) m_phase = 0;
            end
        end
        m_busy = (m_phase != 0);
    endtask

    // Monitor: each output cycle pops the entry pushed one edge before the latest.
    always @(negedge clk) begin
        if (started) begin
            if (q.size() >= 2) begin
                exp_t e;
                e = q.pop_front();
                check("rgb_o",   32'(rgb_o),   32'(e.rgb));
                check("de_o",    32'(de_o),    32'(e.de));
                check("hsync_o", 32'(hsync_o), 32'(e.hs));
                check("vsync_o", 32'(vsync_o), 32'(e.vs));
            end
            check("busy_o", 32'(busy_o), 32'(m_busy));
        end
    end

    task automatic rand_inputs();
        de_i       = ($urandom_range(0, 7) != 0);
        hsync_i    = $urandom_range(0, 1) == 1;
        vsync_i    = $urandom_range(0, 1) == 1;
        menu_rgb_i = 24'($urandom);
        for (int k = 0; k < NL; k++)
            layer_rgb_i[k*24 +: 24] = ($urandom_range(0, 2) == 0) ? KEY : 24'($urandom);
        layer_en_i    = 4'($urandom);
        frame_start_i = 1'b0;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        started = 1;
        model_step();
        #1;
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int c = 0; c < FLEN; c++) begin
                rand_inputs();
                frame_start_i = (c == 0);
                clock_edge();
            end
    endtask

    // Change the request away from frame_start so the dark-point handoff is unambiguous.
    task automatic set_mode(input int m);
        mode_i = 2'(m);
        for (int c = 0; c < 2; c++) begin
            rand_inputs();
            clock_edge();
        end
    endtask

    initial begin
        rst_i  = 1'b1;
        mode_i = 2'd0;
        rand_inputs();
        for (int c = 0; c < 3; c++) clock_edge();
        rst_i = 1'b0;

        // MENU steady, including blanked pixels
        run_frames(2);
        rand_inputs();
        de_i = 1'b0; menu_rgb_i = 24'hFFFFFF;
        clock_edge();

        // First fade after reset, with mode change coinciding with frame_start in SHOW
        rand_inputs();
        mode_i = 2'd1; frame_start_i = 1'b1;
        clock_edge();
        run_frames(34);

        // Priority and colour key in PLAYING
        rand_inputs();
        de_i = 1'b1; layer_en_i = 4'b0110;
        layer_rgb_i[1*24 +: 24] = 24'h000000;
        layer_rgb_i[2*24 +: 24] = 24'h112233;
        clock_edge();
        rand_inputs();
        de_i = 1'b1; layer_en_i = 4'b0000;
        clock_edge();
        run_frames(1);

        // Reverse mid fade-in
        set_mode(0);
        run_frames(16 + 5);
        set_mode(2);
        run_frames(24);

        // Retarget during fade-out: PLAYING then FINAL
        set_mode(1);
        run_frames(2);
        set_mode(3);
        run_frames(34);

        // Request returns to the active mode during fade-out
        set_mode(0);
        run_frames(3);
        set_mode(3);
        run_frames(34);

        // Reset in the middle of a fade-out
        set_mode(1);
        run_frames(3);
        rand_inputs();
        rst_i = 1'b1;
        clock_edge();
        rst_i  = 1'b0;
        mode_i = 2'd0;
        run_frames(2);

        // Random mode traffic
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) set_mode(int'($urandom_range(0, 3)));
            run_frames(1);
        end

        for (int c = 0; c < 3; c++) begin
            rand_inputs();
            clock_edge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
